dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter and sequencer in front of the single-port `data_memory` block (1024 × 32-bit words, byte addressing via `address[11:2]`, one-cycle synchronous read). It shares the memory between the processor load/store path (CPU port) and a debug/loader port (DBG port). It runs one transaction at a time, generates `mem_write`/`address`/`write_data`, and returns read data to the owning requester with a valid pulse. It also blocks out-of-range accesses so they never reach the RAM.

## Interface
- `ADDR_W`, 32, address width of all ports
- `DATA_W`, 32, data width of all ports
- `MEM_WORDS`, 1024, RAM depth in words; legal byte range is 0 .. MEM_WORDS*4-1
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `cpu_req`  in  1  CPU request; held with attributes until `cpu_gnt`
- `cpu_we`  in  1  1 = write, 0 = read
- `cpu_addr`  in  ADDR_W  byte address; bits [1:0] ignored
- `cpu_wdata`  in  DATA_W  write data
- `cpu_gnt`  out  1  one-cycle accept pulse
- `cpu_rvalid`  out  1  one-cycle read-response pulse
- `cpu_rdata`  out  DATA_W  read data; held until the next CPU read response
- `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_wdata`, `dbg_gnt`, `dbg_rvalid`, `dbg_rdata`: same as the CPU set, for the debug/loader port
- `mem_write`  out  1  to `data_memory.mem_write`
- `mem_addr`  out  ADDR_W  to `data_memory.address`
- `mem_wdata`  out  DATA_W  to `data_memory.write_data`
- `mem_rdata`  in  DATA_W  from `data_memory.read_data`
- `busy`  out  1  high whenever state ≠ IDLE
- `err`  out  1  one-cycle pulse on an out-of-range access

## Operation
- **FSM states:** IDLE, ISSUE, READ, RESP.
- **IDLE:**
  - If any request is present, choose an owner and latch owner, `we`, `addr`, `wdata` and a range flag; go to ISSUE.
  - Otherwise stay in IDLE.
- **ISSUE:**
  - Assert the owner's `gnt` and drive the `mem_*` outputs from the latched values.
  - For an in-range write, `mem_write` = 1. Write goes to IDLE.
  - Read goes to READ.
- **READ:** `mem_rdata` is valid in this cycle. Latch it into the owner's `rdata`, or 32'hDEADBEEF if out of range. Go to RESP.
- **RESP:** Pulse the owner's `rvalid` for one cycle. Go to IDLE.
- **Arbitration (default build):** fixed priority, CPU over DBG. DBG can starve under continuous CPU traffic.
- **Out of range** (`addr >= MEM_WORDS*4`):
  - Still granted.
  - `err` pulses in ISSUE.
  - Write: `mem_write` is forced to 0.
  - Read: completes normally and returns 32'hDEADBEEF.
- **`mem_addr` / `mem_wdata`:** keep their last values outside ISSUE. `mem_write` is 1 only in ISSUE.
- **Requester contract:**
  - A requester may drop `req` or change its attributes in the cycle after `gnt`.
  - Requests are not accepted outside IDLE.
- **Reset values:** all outputs 0, `*_rdata` = 0, state = IDLE, round-robin pointer = DBG so CPU wins first.
- **Reset mid-transaction:** reset is asynchronous. The in-flight transaction is dropped, no `rvalid` is produced, and any write already issued in ISSUE stays in RAM.

## Timing
- Request sampled high in IDLE at cycle T → `gnt` and `mem_*` driven in T+1.
- Write lands at the end of T+1. Next accept is possible at T+2, so writes take 2 cycles each.
- Read: RAM latches at the end of T+1, `mem_rdata` is valid in T+2, `rvalid`/`rdata` appear in T+3. Next accept at T+4, so reads take 4 cycles each.
- Simultaneous requests in IDLE: exactly one `gnt` is issued. The loser stays pending and is accepted at the next IDLE.
- `gnt` never asserts in the same cycle as `rvalid` of a different transaction.

## Configuration
- **`DMEM_ARB_RR_EN` defined:**
  - Round-robin arbitration. The pointer records the last-granted port and updates in ISSUE.
  - When both ports request, the port not last granted wins.
  - With one requester, that requester always wins.
- **Not defined:** fixed CPU priority. The pointer register is not built.

## Structure
- **Package `dmem_arb_pkg`:**
  - state enum {IDLE, ISSUE, READ, RESP}
  - owner enum {OWN_CPU, OWN_DBG}
  - constant `OOR_READ_VAL` = 32'hDEADBEEF
  - default `MEM_WORDS`
- **Sub-module `dmem_rr_arbiter`:** 2-way grant selection with inputs req[1:0], update strobe, clk, rst_n; output one-hot select.
  - Contains the pointer when `DMEM_ARB_RR_EN` is defined.
  - Purely fixed-priority otherwise.

## Test plan
- CPU write of 0x0000_0010 ← 0x1234_5678, then read of 0x10 → `mem_write` for exactly one cycle at T+1, `cpu_rdata` = 0x1234_5678 with `cpu_rvalid` at T+3 of the read.
- CPU and DBG reads requested in the same cycle, sustained:
  - Default build: CPU served every time.
  - `DMEM_ARB_RR_EN`: grants alternate CPU, DBG, CPU, …, with the first grant to CPU.
- DBG write to 0x0000_1000 (out of range) → `err` pulse, `mem_write` stays 0, RAM word 0 unchanged. DBG read of 0x1000 → `dbg_rdata` = 0xDEADBEEF.
- Read of 0x0000_0007 → same data as 0x4, since bits [1:0] are ignored.
- `rst_n` asserted in the READ state → outputs 0 immediately, no `rvalid` after release, state IDLE, next request granted normally.
- Back-to-back CPU writes to 0x0, 0x4, 0x8 with `req` held → grants at 2-cycle spacing, `busy` never low for more than one cycle between them.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, owner enum, out-of-range read value, default RAM depth.
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      READ  = 2'd2,
      RESP  = 2'd3
   } state_t;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_DBG = 1'b1
   } owner_t;

   // Returned instead of RAM data when a read falls outside the RAM
   localparam logic [31:0] OOR_READ_VAL = 32'hDEADBEEF;

   // data_memory depth in 32-bit words
   localparam int DEF_MEM_WORDS = 1024;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side request/response bundle for one port of the memory arbiter.
// Latency: n/a (wires only).
// Backpressure: req is held with its attributes until gnt pulses.
// Ports: master = requester (drives req/we/addr/wdata), slave = arbiter
//        (drives gnt, rvalid pulse and held rdata).
interface dmem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              gnt;
   logic              rvalid;
   logic [DATA_W-1:0] rdata;

   modport master (
      output req, we, addr, wdata,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, we, addr, wdata,
      output gnt, rvalid, rdata
   );
endinterface

// File: rtl/dmem_rr_arbiter.sv
// Two-way grant selector for the memory arbiter (bit 0 = CPU, bit 1 = DBG).
// Latency: combinational select; pointer (if built) updates on the upd strobe.
// Backpressure: none; caller only samples sel when it can accept.
// Ports: req[1:0] requests, upd strobe with upd_dbg = port granted, sel one-hot.
// Build option: DMEM_ARB_RR_EN selects round-robin, otherwise fixed CPU priority.
module dmem_rr_arbiter (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       upd,
   input  logic       upd_dbg,
   output logic [1:0] sel
);

`ifdef DMEM_ARB_RR_EN
   // Last granted port; resets to DBG so the CPU wins the first contest
   logic last_dbg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_dbg <= 1'b1;
      end else if (upd) begin
         last_dbg <= upd_dbg;
      end
   end

   always_comb begin
      sel = req;
      if (req == 2'b11) begin
         sel = last_dbg ? 2'b01 : 2'b10;
      end
   end
`else
   // Pointer not built in the fixed-priority variant
   logic unused_rr;
   assign unused_rr = ^{clk, rst_n, upd, upd_dbg};

   always_comb begin
      sel = 2'b00;
      if (req[0]) begin
         sel = 2'b01;
      end else if (req[1]) begin
         sel = 2'b10;
      end
   end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data_memory between CPU and DBG requesters, one transaction at a time.
// Latency: gnt/mem_* one cycle after req seen in IDLE; write 2 cycles, read data + rvalid 3 cycles after req.
// Backpressure: requests wait (req held) while busy; out-of-range accesses are granted but never reach the RAM.
// Ports: clk, rst_n; cpu/dbg request bundles (slave modport); mem_write/mem_addr/mem_wdata/mem_rdata
//        to data_memory; busy (not IDLE); err (one-cycle pulse on out-of-range access).
// Build option: DMEM_ARB_RR_EN enables round-robin arbitration (see dmem_rr_arbiter).
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MEM_WORDS = DEF_MEM_WORDS
) (
   input  logic              clk,
   input  logic              rst_n,
   dmem_arbiter_if.slave     cpu,
   dmem_arbiter_if.slave     dbg,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              err
);

   // First byte address past the end of the RAM
   localparam logic [ADDR_W-1:0] OOR_BASE = ADDR_W'(MEM_WORDS * 4);

   state_t            state_q, state_d;
   owner_t            own_q;
   logic              we_q;
   logic              oor_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] cpu_rdata_q;
   logic [DATA_W-1:0] dbg_rdata_q;

   logic [1:0]        sel;
   logic              accept;
   logic              pick_dbg;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic [DATA_W-1:0] rd_val;

   logic cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid;

   dmem_rr_arbiter u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     ({dbg.req, cpu.req}),
      .upd     (state_q == ISSUE),
      .upd_dbg (own_q == OWN_DBG),
      .sel     (sel)
   );

   assign accept    = (state_q == IDLE) && (cpu.req || dbg.req);
   assign pick_dbg  = sel[1];
   assign req_we    = pick_dbg ? dbg.we    : cpu.we;
   assign req_addr  = pick_dbg ? dbg.addr  : cpu.addr;
   assign req_wdata = pick_dbg ? dbg.wdata : cpu.wdata;
   assign rd_val    = oor_q ? DATA_W'(OOR_READ_VAL) : mem_rdata;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = ISSUE;
         ISSUE:   state_d = we_q ? IDLE : READ;
         READ:    state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output decode: grant/write/err live in ISSUE, response pulse in RESP
   always_comb begin
      cpu_gnt    = 1'b0;
      dbg_gnt    = 1'b0;
      cpu_rvalid = 1'b0;
      dbg_rvalid = 1'b0;
      mem_write  = 1'b0;
      err        = 1'b0;
      case (state_q)
         ISSUE: begin
            cpu_gnt   = (own_q == OWN_CPU);
            dbg_gnt   = (own_q == OWN_DBG);
            mem_write = we_q && !oor_q;
            err       = oor_q;
         end
         RESP: begin
            cpu_rvalid = (own_q == OWN_CPU);
            dbg_rvalid = (own_q == OWN_DBG);
         end
         default: ;
      endcase
   end

   // Transaction latch; only loaded on accept, so mem_addr/mem_wdata
   // keep the last issued values in every other cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         own_q   <= OWN_CPU;
         we_q    <= 1'b0;
         oor_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (accept) begin
         own_q   <= pick_dbg ? OWN_DBG : OWN_CPU;
         we_q    <= req_we;
         oor_q   <= (req_addr >= OOR_BASE);
         addr_q  <= req_addr;
         wdata_q <= req_wdata;
      end
   end

   // Read data captured in READ, held until that port's next read response
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cpu_rdata_q <= '0;
         dbg_rdata_q <= '0;
      end else if (state_q == READ) begin
         if (own_q == OWN_CPU) begin
            cpu_rdata_q <= rd_val;
         end else begin
            dbg_rdata_q <= rd_val;
         end
      end
   end

   assign mem_addr   = addr_q;
   assign mem_wdata  = wdata_q;
   assign busy       = (state_q != IDLE);

   assign cpu.gnt    = cpu_gnt;
   assign cpu.rvalid = cpu_rvalid;
   assign cpu.rdata  = cpu_rdata_q;
   assign dbg.gnt    = dbg_gnt;
   assign dbg.rvalid = dbg_rvalid;
   assign dbg.rdata  = dbg_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter with a behavioural data_memory.
// Stimulus pushes expected gnt/write/err/response events (with cycle numbers);
// a negedge monitor pops and compares whenever the DUT presents one.
module tb_dmem_arbiter;

   localparam logic [1:0] K_GNT  = 2'd0;
   localparam logic [1:0] K_WR   = 2'd1;
   localparam logic [1:0] K_ERR  = 2'd2;
   localparam logic [1:0] K_RESP = 2'd3;

   typedef struct packed {
      logic [1:0]  kind;
      logic [1:0]  port;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] cyc;
   } evt_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   checks;
   int   failures;
   evt_t exp_q[$];

   logic        mem_write;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        busy;
   logic        err;
   logic [31:0] ram [0:1023];

   dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) cpu_if ();
   dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) dbg_if ();

   dmem_arbiter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cpu       (cpu_if),
      .dbg       (dbg_if),
      .mem_write (mem_write),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .busy      (busy),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // data_memory: synchronous write, one-cycle registered read
   initial begin
      for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
      mem_rdata = 32'h0;
   end
   always @(posedge clk) begin
      if (mem_write) ram[mem_addr[11:2]] <= mem_wdata;
      mem_rdata <= ram[mem_addr[11:2]];
   end

   function automatic evt_t mk(logic [1:0] kind, logic [1:0] port,
                               logic [31:0] addr, logic [31:0] data, int c);
      evt_t e;
      e.kind = kind;
      e.port = port;
      e.addr = addr;
      e.data = data;
      e.cyc  = 32'(c);
      return e;
   endfunction

   function automatic string kname(logic [1:0] k);
      case (k)
         K_GNT:   return "gnt";
         K_WR:    return "mem_write";
         K_ERR:   return "err";
         default: return "rvalid";
      endcase
   endfunction

   task automatic push(logic [1:0] kind, logic [1:0] port,
                       logic [31:0] addr, logic [31:0] data, int c);
      exp_q.push_back(mk(kind, port, addr, data, c));
   endtask

   task automatic observe(evt_t o);
      evt_t e;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL unexpected_%s actual: port=%0d addr=%h data=%h cyc=%0d required: no event",
                  kname(o.kind), o.port, o.addr, o.data, o.cyc);
      end else begin
         e = exp_q.pop_front();
         if (o !== e) begin
            failures++;
            $display("FAIL event_%s actual: kind=%s port=%0d addr=%h data=%h cyc=%0d required: kind=%s port=%0d addr=%h data=%h cyc=%0d",
                     kname(e.kind), kname(o.kind), o.port, o.addr, o.data, o.cyc,
                     kname(e.kind), e.port, e.addr, e.data, e.cyc);
         end
      end
   endtask

   // Monitor: port code 2 means both ports signalled at once
   always @(negedge clk) begin
      if (cpu_if.gnt || dbg_if.gnt)
         observe(mk(K_GNT, (cpu_if.gnt && dbg_if.gnt) ? 2'd2 : (dbg_if.gnt ? 2'd1 : 2'd0),
                    32'h0, 32'h0, cyc));
      if (mem_write)
         observe(mk(K_WR, 2'd0, mem_addr, mem_wdata, cyc));
      if (err)
         observe(mk(K_ERR, 2'd0, 32'h0, 32'h0, cyc));
      if (cpu_if.rvalid || dbg_if.rvalid)
         observe(mk(K_RESP, (cpu_if.rvalid && dbg_if.rvalid) ? 2'd2 : (dbg_if.rvalid ? 2'd1 : 2'd0),
                    32'h0, dbg_if.rvalid ? dbg_if.rdata : cpu_if.rdata, cyc));
   end

   task automatic chk(string name, logic [31:0] act, logic [31:0] req_v);
      checks++;
      if (act !== req_v) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(bit port, bit rq, bit we, logic [31:0] addr, logic [31:0] wdata);
      if (!port) begin
         cpu_if.req = rq; cpu_if.we = we; cpu_if.addr = addr; cpu_if.wdata = wdata;
      end else begin
         dbg_if.req = rq; dbg_if.we = we; dbg_if.addr = addr; dbg_if.wdata = wdata;
      end
   endtask

   // One uncontested transaction starting in an IDLE cycle; returns in an IDLE cycle
   task automatic single(bit port, bit we, logic [31:0] addr, logic [31:0] wdata,
                         logic [31:0] rexp);
      int  c;
      bit  oor;
      c   = cyc;
      oor = (addr >= 32'h1000);
      drive(port, 1'b1, we, addr, wdata);
      push(K_GNT, {1'b0, port}, 32'h0, 32'h0, c + 1);
      if (we && !oor) push(K_WR, 2'd0, addr, wdata, c + 1);
      if (oor)        push(K_ERR, 2'd0, 32'h0, 32'h0, c + 1);
      if (!we)        push(K_RESP, {1'b0, port}, 32'h0, rexp, c + 3);
      tick();
      tick();
      drive(port, 1'b0, 1'b0, 32'h0, 32'h0);
      if (!we) begin
         tick();
         tick();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int  c;
      bit  mid;
      checks   = 0;
      failures = 0;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      rst_n = 1'b0;
      tick();
      tick();

      // Reset state
      chk("rst_busy",       32'(busy), 32'h0);
      chk("rst_err",        32'(err), 32'h0);
      chk("rst_mem_write",  32'(mem_write), 32'h0);
      chk("rst_mem_addr",   mem_addr, 32'h0);
      chk("rst_mem_wdata",  mem_wdata, 32'h0);
      chk("rst_gnt",        32'({cpu_if.gnt, dbg_if.gnt}), 32'h0);
      chk("rst_rvalid",     32'({cpu_if.rvalid, dbg_if.rvalid}), 32'h0);
      chk("rst_cpu_rdata",  cpu_if.rdata, 32'h0);
      chk("rst_dbg_rdata",  dbg_if.rdata, 32'h0);
      rst_n = 1'b1;
      tick();

      // Basic write then read back
      single(1'b0, 1'b1, 32'h10, 32'h1234_5678, 32'h0);
      single(1'b0, 1'b0, 32'h10, 32'h0, 32'h1234_5678);

      // Byte offset bits ignored
      single(1'b0, 1'b1, 32'h4, 32'h0BAD_F00D, 32'h0);
      single(1'b0, 1'b0, 32'h7, 32'h0, 32'h0BAD_F00D);

      // Out-of-range from DBG: 0x1000 would alias word 0 if it reached the RAM
      single(1'b0, 1'b1, 32'h0, 32'hA5A5_A5A5, 32'h0);
      single(1'b1, 1'b1, 32'h1000, 32'hFFFF_FFFF, 32'h0);
      chk("oor_ram_word0", ram[0], 32'hA5A5_A5A5);
      single(1'b1, 1'b0, 32'h1000, 32'h0, 32'hDEAD_BEEF);
      single(1'b1, 1'b0, 32'h0, 32'h0, 32'hA5A5_A5A5);

      // Sustained simultaneous reads; last grant so far went to DBG
`ifdef DMEM_ARB_RR_EN
      mid = 1'b1;
`else
      mid = 1'b0;
`endif
      c = cyc;
      drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
      drive(1'b1, 1'b1, 1'b0, 32'h4, 32'h0);
      push(K_GNT,  2'd0, 32'h0, 32'h0, c + 1);
      push(K_RESP, 2'd0, 32'h0, 32'h1234_5678, c + 3);
      push(K_GNT,  {1'b0, mid}, 32'h0, 32'h0, c + 5);
      push(K_RESP, {1'b0, mid}, 32'h0, mid ? 32'h0BAD_F00D : 32'h1234_5678, c + 7);
      push(K_GNT,  2'd0, 32'h0, 32'h0, c + 9);
      push(K_RESP, 2'd0, 32'h0, 32'h1234_5678, c + 11);
      push(K_GNT,  2'd1, 32'h0, 32'h0, c + 13);
      push(K_RESP, 2'd1, 32'h0, 32'h0BAD_F00D, c + 15);
      repeat (10) tick();
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      repeat (4) tick();
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      repeat (2) tick();

      // Back-to-back writes with req held, attributes changed after each gnt
      c = cyc;
      drive(1'b0, 1'b1, 1'b1, 32'h0, 32'h1111_1111);
      push(K_GNT, 2'd0, 32'h0, 32'h0, c + 1);
      push(K_WR,  2'd0, 32'h0, 32'h1111_1111, c + 1);
      push(K_GNT, 2'd0, 32'h0, 32'h0, c + 3);
      push(K_WR,  2'd0, 32'h4, 32'h2222_2222, c + 3);
      push(K_GNT, 2'd0, 32'h0, 32'h0, c + 5);
      push(K_WR,  2'd0, 32'h8, 32'h3333_3333, c + 5);
      tick(); chk("b2b_busy_1", 32'(busy), 32'h1);
      tick(); chk("b2b_busy_2", 32'(busy), 32'h0);
      drive(1'b0, 1'b1, 1'b1, 32'h4, 32'h2222_2222);
      tick(); chk("b2b_busy_3", 32'(busy), 32'h1);
      tick(); chk("b2b_busy_4", 32'(busy), 32'h0);
      drive(1'b0, 1'b1, 1'b1, 32'h8, 32'h3333_3333);
      tick(); chk("b2b_busy_5", 32'(busy), 32'h1);
      tick(); chk("b2b_busy_6", 32'(busy), 32'h0);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      single(1'b0, 1'b0, 32'h8, 32'h0, 32'h3333_3333);

      // Reset while in READ: transaction dropped, no response afterwards
      c = cyc;
      drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
      push(K_GNT, 2'd0, 32'h0, 32'h0, c + 1);
      tick();
      tick();
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_busy",      32'(busy), 32'h0);
      chk("midrst_cpu_rdata", cpu_if.rdata, 32'h0);
      chk("midrst_mem_addr",  mem_addr, 32'h0);
      chk("midrst_rvalid",    32'({cpu_if.rvalid, dbg_if.rvalid}), 32'h0);
      tick();
      tick();
      rst_n = 1'b1;
      repeat (4) tick();
      chk("postrst_busy", 32'(busy), 32'h0);
      single(1'b1, 1'b0, 32'h10, 32'h0, 32'h1234_5678);

      tick();
      chk("queue_drained", 32'(exp_q.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
